// File: rtl/dr_pkg.sv
// Shared types and constants for the data-recovery receive sequencer.
//   state_e : receive FSM states
//   ERR_*   : err_code values reported on dr_rx_ctrl.err_code
package dr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HUNT,
    ACTIVE,
    EOP,
    FLUSH
  } state_e;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_STUFF  = 2'd1;
  localparam logic [1:0] ERR_FIFO   = 2'd2;
  localparam logic [1:0] ERR_BABBLE = 2'd3;

endpackage

// File: rtl/nrzi_destuff.sv
// NRZI decoder and bit-destuffer for the recovered bit stream.
//   clk, reset   : bit clock, synchronous active-high reset
//   clear        : return to line-idle (prev_bit=J) with ones count cleared
//   active       : count ones and qualify bits (parent is framing a packet)
//   dr_bit       : recovered NRZI bit, dr_valid its qualifier
//   dec_c        : decoded bit for the current dr_bit
//   emit_c       : decoded bit is payload (not a stuffed 0)
//   stuff_err_c  : a 1 arrived where a stuffed 0 was required
module nrzi_destuff #(
  parameter int unsigned STUFF_LEN = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic active,
  input  logic dr_bit,
  input  logic dr_valid,
  output logic dec_c,
  output logic emit_c,
  output logic stuff_err_c
);

  localparam int unsigned OW = $clog2(STUFF_LEN + 1);

  logic          prev_bit;
  logic [OW-1:0] ones_cnt;
  logic          at_limit;

  assign dec_c       = ~(dr_bit ^ prev_bit);
  assign at_limit    = (ones_cnt == OW'(STUFF_LEN));
  // After STUFF_LEN ones the next bit must be a stuffed 0: drop it, or flag a 1.
  assign emit_c      = active & dr_valid & ~at_limit;
  assign stuff_err_c = active & dr_valid & dec_c & at_limit;

  // Line history and run-of-ones counter; both frozen while dr_valid is low.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      prev_bit <= 1'b1;
      ones_cnt <= '0;
    end else if (dr_valid) begin
      prev_bit <= dr_bit;
      if (active) begin
        if (!dec_c)        ones_cnt <= '0;
        else if (!at_limit) ones_cnt <= ones_cnt + OW'(1);
      end
    end
  end

endmodule

// File: rtl/dr_rx_ctrl.sv
// Receive-side sequencer: hunts SYNC, frames destuffed packet bits up to SE0 EOP,
// and flushes the AD-FIFO after every packet or error.
//   clock_480, reset           : bit clock, synchronous active-high reset
//   enable                     : 0 parks the sequencer in IDLE
//   dr_bit, dr_valid           : recovered NRZI bit stream from the AD-FIFO
//   se0                        : line SE0 indication
//   fifo_underflow/overflow    : AD-FIFO fault flags
//   fifo_reset                 : AD-FIFO clear, high while flushing
//   rx_active                  : packet in progress
//   rx_bit, rx_bit_valid       : decoded, destuffed payload bit
//   rx_error, err_code         : error pulse and sticky code (cleared at next SYNC)
module dr_rx_ctrl
  import dr_pkg::*;
#(
  parameter int unsigned SYNC_MIN_ZEROS = 5,
  parameter int unsigned STUFF_LEN      = 6,
  parameter int unsigned EOP_SE0_BITS   = 2,
  parameter int unsigned FLUSH_CYCLES   = 4,
  parameter int unsigned MAX_PKT_BITS   = 8216
) (
  input  logic       clock_480,
  input  logic       reset,
  input  logic       enable,
  input  logic       dr_bit,
  input  logic       dr_valid,
  input  logic       se0,
  input  logic       fifo_underflow,
  input  logic       fifo_overflow,
  output logic       fifo_reset,
  output logic       rx_active,
  output logic       rx_bit,
  output logic       rx_bit_valid,
  output logic       rx_error,
  output logic [1:0] err_code
);

  localparam int unsigned ZW = $clog2(SYNC_MIN_ZEROS + 1);
  localparam int unsigned SW = $clog2(EOP_SE0_BITS + 1);
  localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned BW = $clog2(MAX_PKT_BITS + 1);

  state_e        state, state_nxt;
  logic [ZW-1:0] zero_cnt, zero_nxt;
  logic [SW-1:0] se0_cnt, se0_nxt;
  logic [FW-1:0] flush_cnt, flush_nxt;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic [1:0]    err_code_nxt;
  logic          rx_error_nxt, rx_bit_nxt, rx_bit_valid_nxt;
  logic          clear_c, active_c;
  logic          dec_c, emit_c, stuff_err_c;
  logic          fifo_err_c, eop_done_c, babble_c;

  assign active_c   = (state == ACTIVE);
  assign fifo_err_c = fifo_underflow | fifo_overflow;
  assign eop_done_c = se0 && (se0_cnt == SW'(EOP_SE0_BITS - 1));
  assign babble_c   = emit_c && (bit_cnt == BW'(MAX_PKT_BITS));

  nrzi_destuff #(
    .STUFF_LEN (STUFF_LEN)
  ) u_destuff (
    .clk         (clock_480),
    .reset       (reset),
    .clear       (clear_c),
    .active      (active_c),
    .dr_bit      (dr_bit),
    .dr_valid    (dr_valid),
    .dec_c       (dec_c),
    .emit_c      (emit_c),
    .stuff_err_c (stuff_err_c)
  );

  // Next-state, counter and output decode.
  always_comb begin
    state_nxt        = state;
    zero_nxt         = zero_cnt;
    se0_nxt          = se0_cnt;
    flush_nxt        = flush_cnt;
    bit_nxt          = bit_cnt;
    err_code_nxt     = err_code;
    rx_error_nxt     = 1'b0;
    rx_bit_nxt       = rx_bit;
    rx_bit_valid_nxt = 1'b0;
    clear_c          = 1'b0;

    case (state)
      IDLE: begin
        clear_c = 1'b1;
        if (enable) begin
          state_nxt = FLUSH;
          flush_nxt = '0;
        end
      end
      HUNT: begin
        if (dr_valid) begin
          if (!dec_c) begin
            if (zero_cnt < ZW'(SYNC_MIN_ZEROS)) zero_nxt = zero_cnt + ZW'(1);
          end else if (zero_cnt >= ZW'(SYNC_MIN_ZEROS)) begin
            state_nxt    = ACTIVE;
            err_code_nxt = ERR_NONE;
          end else begin
            zero_nxt = '0;
          end
        end
      end
      ACTIVE: begin
        se0_nxt = se0 ? se0_cnt + SW'(1) : '0;
        // Fault priority: fifo, stuff, babble, then EOP; errors emit nothing.
        if (fifo_err_c || stuff_err_c || babble_c) begin
          state_nxt    = FLUSH;
          flush_nxt    = '0;
          rx_error_nxt = 1'b1;
          if (fifo_err_c)       err_code_nxt = ERR_FIFO;
          else if (stuff_err_c) err_code_nxt = ERR_STUFF;
          else                  err_code_nxt = ERR_BABBLE;
        end else if (eop_done_c) begin
          state_nxt = EOP;
        end else if (emit_c) begin
          rx_bit_valid_nxt = 1'b1;
          rx_bit_nxt       = dec_c;
          bit_nxt          = bit_cnt + BW'(1);
        end
      end
      EOP: begin
        if (!se0) begin
          state_nxt = FLUSH;
          flush_nxt = '0;
        end
      end
      FLUSH: begin
        if (flush_cnt == FW'(FLUSH_CYCLES - 1)) begin
          state_nxt = HUNT;
          clear_c   = 1'b1;
        end else begin
          flush_nxt = flush_cnt + FW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Disable is a silent abort from any state.
    if (!enable) begin
      state_nxt        = IDLE;
      rx_error_nxt     = 1'b0;
      rx_bit_valid_nxt = 1'b0;
      err_code_nxt     = err_code;
    end

    if (state_nxt != HUNT)   zero_nxt = '0;
    if (state_nxt != ACTIVE) begin
      se0_nxt = '0;
      bit_nxt = '0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock_480) begin
    if (reset) begin
      state        <= IDLE;
      zero_cnt     <= '0;
      se0_cnt      <= '0;
      flush_cnt    <= '0;
      bit_cnt      <= '0;
      fifo_reset   <= 1'b0;
      rx_active    <= 1'b0;
      rx_bit       <= 1'b0;
      rx_bit_valid <= 1'b0;
      rx_error     <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      state        <= state_nxt;
      zero_cnt     <= zero_nxt;
      se0_cnt      <= se0_nxt;
      flush_cnt    <= flush_nxt;
      bit_cnt      <= bit_nxt;
      fifo_reset   <= (state_nxt == FLUSH);
      rx_active    <= (state_nxt == ACTIVE);
      rx_bit       <= rx_bit_nxt;
      rx_bit_valid <= rx_bit_valid_nxt;
      rx_error     <= rx_error_nxt;
      err_code     <= err_code_nxt;
    end
  end

endmodule

// File: tb/tb_dr_rx_ctrl.sv
// Self-checking bench for dr_rx_ctrl: packets are built as decoded payload,
// NRZI-encoded with bit stuffing by the bench, and the received bit stream,
// error pulses and FIFO flush lengths are compared against the payload.
module tb_dr_rx_ctrl;

  localparam int MAX_BITS = 8216;

  logic       clk = 1'b0;
  logic       reset, enable, dr_bit, dr_valid, se0, fifo_underflow, fifo_overflow;
  logic       fifo_reset, rx_active, rx_bit, rx_bit_valid, rx_error;
  logic [1:0] err_code;

  int n_vec = 0;
  int n_bad = 0;
  int n_frst, n_rxerr;
  bit got_q[$];
  bit exp_q[$];
  bit line;
  bit gaps;

  always #5 clk = ~clk;

  dr_rx_ctrl dut (
    .clock_480      (clk),
    .reset          (reset),
    .enable         (enable),
    .dr_bit         (dr_bit),
    .dr_valid       (dr_valid),
    .se0            (se0),
    .fifo_underflow (fifo_underflow),
    .fifo_overflow  (fifo_overflow),
    .fifo_reset     (fifo_reset),
    .rx_active      (rx_active),
    .rx_bit         (rx_bit),
    .rx_bit_valid   (rx_bit_valid),
    .rx_error       (rx_error),
    .err_code       (err_code)
  );

  // Passive monitor: collects emitted bits, error pulses, flush cycles.
  always @(negedge clk) begin
    if (rx_bit_valid === 1'b1) got_q.push_back(rx_bit);
    if (rx_error === 1'b1) n_rxerr++;
    if (fifo_reset === 1'b1) n_frst++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic b, input logic v, input logic s, input logic ovf);
    @(negedge clk);
    dr_bit        = b;
    dr_valid      = v;
    se0           = s;
    fifo_overflow = ovf;
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(line, 1'b0, 1'b0, 1'b0);
  endtask

  // Send one decoded bit as NRZI: 0 toggles the line, 1 holds it.
  task automatic send_dec(input bit d);
    if (gaps && $urandom_range(3) == 0) begin
      repeat ($urandom_range(2, 1)) drive(1'($urandom_range(1)), 1'b0, 1'b0, 1'b0);
    end
    if (!d) line = ~line;
    drive(line, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic send_sync();
    for (int i = 0; i < 7; i++) send_dec(1'b0);
    sample();
    chk("sync_pre_active", rx_active, 0);
    send_dec(1'b1);
    sample();
    chk("sync_active", rx_active, 1);
    chk("sync_err_clear", err_code, 0);
  endtask

  // Payload with a stuffed 0 after every six consecutive 1s.
  task automatic send_payload();
    int ones = 0;
    foreach (exp_q[i]) begin
      send_dec(exp_q[i]);
      ones = exp_q[i] ? ones + 1 : 0;
      if (ones == 6) begin
        send_dec(1'b0);
        ones = 0;
      end
    end
  endtask

  task automatic send_eop();
    drive(line, 1'b0, 1'b1, 1'b0);
    drive(line, 1'b0, 1'b1, 1'b0);
    sample();
    chk("eop_rx_active", rx_active, 0);
    line = 1'b1;
    idle(10);
  endtask

  task automatic start_pkt();
    got_q.delete();
    n_rxerr = 0;
    n_frst  = 0;
  endtask

  task automatic fill_rand(input int n, input int pct_one);
    exp_q.delete();
    repeat (n) exp_q.push_back($urandom_range(99) < pct_one);
  endtask

  task automatic check_pkt(input string tag, input int n_bits, input int n_err,
                           input logic [1:0] code);
    int bad = 0;
    chk({tag, "_len"}, got_q.size(), n_bits);
    for (int i = 0; i < n_bits && i < got_q.size(); i++)
      if (got_q[i] != exp_q[i]) bad++;
    chk({tag, "_bits"}, bad, 0);
    chk({tag, "_rx_error"}, n_rxerr, n_err);
    chk({tag, "_err_code"}, err_code, code);
    chk({tag, "_flush_len"}, n_frst, 4);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] a5 = 8'hA5;
    reset = 1'b1; enable = 1'b0; dr_bit = 1'b1; dr_valid = 1'b0; se0 = 1'b0;
    fifo_underflow = 1'b0; fifo_overflow = 1'b0;
    line = 1'b1; gaps = 1'b0;

    // Reset state
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);
    sample();
    chk("rst_fifo_reset", fifo_reset, 0);
    chk("rst_rx_active", rx_active, 0);
    chk("rst_rx_bit", rx_bit, 0);
    chk("rst_rx_bit_valid", rx_bit_valid, 0);
    chk("rst_rx_error", rx_error, 0);
    chk("rst_err_code", err_code, 0);

    // Enable: one FLUSH of four cycles, then HUNT
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0; enable = 1'b1; n_frst = 0;
    idle(10);
    chk("init_flush_len", n_frst, 4);
    chk("init_fifo_reset_low", fifo_reset, 0);
    chk("init_rx_active", rx_active, 0);

    // Payload 0xA5 LSB first
    start_pkt();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(a5[i]);
    send_sync();
    send_payload();
    send_eop();
    check_pkt("a5", 8, 0, 2'd0);

    // Six 1s split by a 3-cycle dr_valid gap, stuffed 0, then 1
    start_pkt();
    exp_q.delete();
    repeat (7) exp_q.push_back(1'b1);
    send_sync();
    for (int i = 0; i < 3; i++) send_dec(1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom_range(1)), 1'b0, 1'b0, 1'b0);
      sample();
      chk("gap_no_valid", rx_bit_valid, 0);
    end
    for (int i = 0; i < 3; i++) send_dec(1'b1);
    send_dec(1'b0);
    send_dec(1'b1);
    send_eop();
    check_pkt("stuff_gap", 7, 0, 2'd0);

    // Seven unstuffed 1s: stuff error on the seventh
    start_pkt();
    exp_q.delete();
    repeat (6) exp_q.push_back(1'b1);
    send_sync();
    for (int i = 0; i < 7; i++) send_dec(1'b1);
    sample();
    chk("stuff_rx_error", rx_error, 1);
    chk("stuff_rx_active", rx_active, 0);
    chk("stuff_err_code", err_code, 1);
    line = 1'b1;
    idle(10);
    check_pkt("stuff_err", 6, 1, 2'd1);

    // Overflow in the cycle that completes SE0 x2: fifo error wins over EOP
    start_pkt();
    fill_rand(5, 50);
    send_sync();
    send_payload();
    drive(line, 1'b0, 1'b1, 1'b0);
    drive(line, 1'b0, 1'b1, 1'b1);
    sample();
    chk("ovf_rx_error", rx_error, 1);
    chk("ovf_err_code", err_code, 2);
    chk("ovf_rx_active", rx_active, 0);
    drive(line, 1'b0, 1'b1, 1'b0);
    sample();
    chk("ovf_flush_not_eop", fifo_reset, 1);
    line = 1'b1;
    idle(10);
    check_pkt("fifo_err", 5, 1, 2'd2);

    // Enable dropped mid-packet: silent return to IDLE
    start_pkt();
    fill_rand(4, 50);
    send_sync();
    send_payload();
    drive(line, 1'b0, 1'b0, 1'b0);
    enable = 1'b0;
    sample();
    chk("dis_rx_active", rx_active, 0);
    chk("dis_rx_bit_valid", rx_bit_valid, 0);
    line = 1'b1;
    idle(5);
    chk("dis_no_error", n_rxerr, 0);
    chk("dis_no_flush", n_frst, 0);
    chk("dis_bits", got_q.size(), 4);
    drive(line, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    idle(10);
    chk("dis_reenable_flush", n_frst, 4);

    // Reset mid-packet
    start_pkt();
    fill_rand(6, 50);
    send_sync();
    send_payload();
    drive(line, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    sample();
    chk("rstm_rx_active", rx_active, 0);
    chk("rstm_rx_error", rx_error, 0);
    drive(line, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    line = 1'b1;
    idle(10);
    chk("rstm_no_error", n_rxerr, 0);
    chk("rstm_flush", n_frst, 4);

    // Random packets, 1-heavy payloads, random dr_valid gaps
    for (int p = 0; p < 6; p++) begin
      start_pkt();
      fill_rand($urandom_range(64, 1), 75);
      gaps = 1'b0;
      send_sync();
      gaps = 1'b1;
      send_payload();
      gaps = 1'b0;
      send_eop();
      check_pkt("rand", exp_q.size(), 0, 2'd0);
    end

    // Babble: one bit past the packet limit
    start_pkt();
    fill_rand(MAX_BITS + 1, 50);
    send_sync();
    send_payload();
    line = 1'b1;
    idle(10);
    check_pkt("babble", MAX_BITS, 1, 2'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
